argmax_sequencer: RTL
=====================

// Module: argmax_sequencer
// PURPOSE
//  Sequential argmax controller for the classifier output stage. Accepts NUM_CLASSES
//  signed scores over a valid/ready stream and keeps a registered running max and its
//  class number. Presents the winning class number and score on a valid/ready result
//  port. It replaces the parallel comparator tree where area matters more than latency.
// PARAMETERS
//  DATA_LEN     `data_len  score width in bits, signed two's complement
//  NUM_CLASSES  10         scores per frame; legal range 2..16
//  NUM_W        4          class-number width; must satisfy 2**NUM_W >= NUM_CLASSES
// PORTS
//  clk        in   1         rising-edge clock, the only clock
//  rst        in   1         synchronous reset, active-high
//  start      in   1         begin a frame; sampled only in IDLE
//  in_valid   in   1         score on in_data is valid
//  in_ready   out  1         block accepts a score this cycle
//  in_data    in   DATA_LEN  signed score; class number = arrival order 0..NUM_CLASSES-1
//  out_valid  out  1         result valid, held until accepted
//  out_ready  in   1         consumer takes the result
//  q_num      out  NUM_W     winning class number
//  q          out  DATA_LEN  winning score, signed
//  busy       out  1         high in ACCUM and in DONE
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready, out_valid and busy = 0; q_num = 0; q = 0; count = 0.
//    A reset mid-frame discards the frame. No result is produced for it.
//  - FSM:
//    IDLE  -> ACCUM when start=1. count is cleared.
//    ACCUM -> DONE on the handshake of score NUM_CLASSES-1.
//    DONE  -> IDLE on the out_valid & out_ready handshake.
//  - in_ready = (state==ACCUM). It is combinational from state only and never depends
//    on in_valid. A score is accepted on in_valid & in_ready.
//  - First accepted score (count==0) loads unconditionally: q <= in_data, q_num <= 0.
//  - Later scores: if in_data > q (signed, strictly greater), then q <= in_data and
//    q_num <= count. Otherwise q and q_num hold.
//  - Ties keep the earlier (lower) class number.
//  - count increments on each accepted score. It reaches NUM_CLASSES-1 and never wraps
//    inside a frame.
//  - Latency: out_valid rises the cycle after the last score handshake. The frame takes
//    NUM_CLASSES+1 cycles minimum from start to out_valid with in_valid held high.
//  - Result stability: out_valid is registered. q and q_num are stable while out_valid=1.
//    q and q_num also hold their values in IDLE until the next frame's first score.
//  - Back-to-back: with out_ready=1, out_valid lasts 1 cycle. A start in the same cycle
//    as the result handshake is ignored, because the block is not yet in IDLE.
//  - start in ACCUM or DONE is ignored.
//  - in_valid outside ACCUM is ignored, and no score is consumed.
//  - Gaps in in_valid stall the frame without limit. No timeout.
// CONFIGURATION
//  ARGMAX_TOP2_EN defined: adds outputs q2_num[NUM_W] and q2[DATA_LEN], the runner-up.
//   - On a new max, the old max moves to q2/q2_num.
//   - Else, if count>0 and (in_data > q2, or count==1), in_data/count load into q2.
//   - Reset and frame start set q2_num=0, q2=most-negative value.
//   - Ties follow the earlier-class-wins rule.
//  ARGMAX_TOP2_EN undefined: the q2 ports and their registers do not exist. Timing and
//   behaviour are otherwise identical.
// TESTING
//  1. Scores 3,-1,7,2,0,5,-8,1,4,6 with in_valid held -> out_valid at cycle 11 after
//     start, q_num=2, q=7. TOP2 build: q2_num=9, q2=6.
//  2. All ten scores = -5 -> q_num=0, q=-5 (tie keeps earliest).
//     Max only in last slot (9 = +100, others 0) -> q_num=9, q=100.
//  3. Signed edges: -32768 in slots 0..8 and -32767 in slot 9 (DATA_LEN=16)
//     -> q_num=9, q=-32767, with no unsigned misorder.
//  4. in_valid toggled 1-0-1-0; out_ready held 0 for 5 cycles -> result unchanged,
//     out_valid stays 1, in_ready=0 in DONE.
//  5. Assert rst at score 4 -> next cycle IDLE, all outputs 0.
//     A fresh frame then completes correctly.
//  6. start pulsed in ACCUM and in DONE, and in_valid asserted in IDLE -> no effect.
//     Checks count and the result.

Source files
------------

// File: rtl/argmax_sequencer.sv
// argmax_sequencer
//   Sequential argmax over one frame of NUM_CLASSES signed scores. The scores
//   arrive on a valid/ready stream. The block keeps a registered running max
//   and its class number, then presents the winner on a valid/ready result port.
//
//   Ports
//     clk, rst          rising-edge clock, synchronous active-high reset
//     start             begin a frame (sampled only in IDLE)
//     in_valid/in_ready score stream; in_ready is a pure decode of state
//     in_data           signed score; class number = arrival order
//     out_valid/ready   result handshake; out_valid held until accepted
//     q_num, q          winning class number and score
//     busy              high while accumulating or holding a result
//
//   Optional feature, macro ARGMAX_TOP2_EN: adds q2_num/q2, the runner-up.
//   DATA_LEN defaults to the `ARGMAX_DATA_LEN macro, which falls back to 16
//   when the build does not supply it.
`ifndef ARGMAX_DATA_LEN
`define ARGMAX_DATA_LEN 16
`endif

module argmax_sequencer #(
  parameter int DATA_LEN    = `ARGMAX_DATA_LEN,
  parameter int NUM_CLASSES = 10,
  parameter int NUM_W       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_LEN-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic        [NUM_W-1:0]    q_num,
  output logic signed [DATA_LEN-1:0] q,
`ifdef ARGMAX_TOP2_EN
  output logic        [NUM_W-1:0]    q2_num,
  output logic signed [DATA_LEN-1:0] q2,
`endif
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [NUM_W-1:0] LAST = NUM_W'(NUM_CLASSES - 1);

  state_t           state;
  logic [NUM_W-1:0] count;
  logic             acc;
  logic             new_max;

  assign in_ready = (state == ACCUM);
  assign busy     = (state != IDLE);
  assign acc      = in_valid & in_ready;
  assign new_max  = in_data > q;   // both operands signed

`ifdef ARGMAX_TOP2_EN
  localparam logic signed [DATA_LEN-1:0] MOST_NEG = {1'b1, {(DATA_LEN-1){1'b0}}};
  logic new_second;
  // The second score always lands in q2 so that a tie with the first still
  // yields a defined runner-up (the later class).
  assign new_second = (in_data > q2) || (count == NUM_W'(1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      q_num     <= '0;
      q         <= '0;
      count     <= '0;
`ifdef ARGMAX_TOP2_EN
      q2_num    <= '0;
      q2        <= MOST_NEG;
`endif
    end else begin
      case (state)
        IDLE: begin
          // q/q_num keep the previous result until the next first score.
          if (start) begin
            state  <= ACCUM;
            count  <= '0;
`ifdef ARGMAX_TOP2_EN
            q2_num <= '0;
            q2     <= MOST_NEG;
`endif
          end
        end
        ACCUM: begin
          if (acc) begin
            if (count == '0) begin
              q     <= in_data;
              q_num <= '0;
            end else if (new_max) begin
              q     <= in_data;
              q_num <= count;
            end
`ifdef ARGMAX_TOP2_EN
            if (count != '0) begin
              if (new_max) begin
                q2     <= q;
                q2_num <= q_num;
              end else if (new_second) begin
                q2     <= in_data;
                q2_num <= count;
              end
            end
`endif
            // count parks on the last class number instead of wrapping.
            if (count == LAST) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              count <= count + NUM_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
